// File: rtl/al_pcie_memwr_sched.sv
// Descriptor scheduler for the RAM-to-PCIe MemWr engine: splits one buffer descriptor
// into MPS-bounded, 4 KB-safe tcq write requests with rolling tags and an in-flight limit.
module al_pcie_memwr_sched #(
    parameter int LOCAL_ADDR_WIDTH  = 17,
    parameter int REMOTE_ADDR_WIDTH = 32,
    parameter int MEM_TAG           = 1,
    parameter int REQUEST_LEN_BITS  = 6,
    parameter int DATA_BITS         = 4,
    parameter int DESC_LEN_BITS     = 16,
    parameter int DESC_ID_BITS      = 4,
    parameter int MAX_INFLIGHT      = 2,
    parameter int MPS_CAP           = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [2:0]                             cfg_max_payload,
    input  logic                                   s_desc_valid,
    output logic                                   s_desc_ready,
    input  logic [LOCAL_ADDR_WIDTH-DATA_BITS-1:0]  s_desc_laddr,
    input  logic [REMOTE_ADDR_WIDTH-DATA_BITS-1:0] s_desc_raddr,
    input  logic [DESC_LEN_BITS-1:0]               s_desc_len,
    input  logic [DESC_ID_BITS-1:0]                s_desc_id,
    output logic                                   m_tcq_valid,
    input  logic                                   m_tcq_ready,
    output logic [LOCAL_ADDR_WIDTH-DATA_BITS-1:0]  m_tcq_laddr,
    output logic [REMOTE_ADDR_WIDTH-DATA_BITS-1:0] m_tcq_raddr,
    output logic [REQUEST_LEN_BITS-1:0]            m_tcq_length,
    output logic [MEM_TAG-1:0]                     m_tcq_tag,
    input  logic                                   m_tcq_cvalid,
    output logic                                   m_tcq_cready,
    input  logic [MEM_TAG-1:0]                     m_tcq_ctag,
    output logic                                   m_done_valid,
    input  logic                                   m_done_ready,
    output logic [DESC_ID_BITS-1:0]                m_done_id,
    output logic                                   err_tag
);

    localparam int LW  = LOCAL_ADDR_WIDTH - DATA_BITS;
    localparam int RW  = REMOTE_ADDR_WIDTH - DATA_BITS;
    localparam int CW  = DESC_LEN_BITS + 1;
    localparam int QW  = REQUEST_LEN_BITS + 1;
    localparam int IW  = MEM_TAG + 1;
    localparam int PGB = 12 - DATA_BITS;

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [LW-1:0]           laddr_q, laddr_d;
    logic [RW-1:0]           raddr_q, raddr_d;
    logic [CW-1:0]           rem_q, rem_d;
    logic [CW-1:0]           mps_q, mps_d;
    logic [QW-1:0]           chunk_q, chunk_d;
    logic [DESC_ID_BITS-1:0] id_q, id_d;
    logic [MEM_TAG-1:0]      tag_q, tag_d;
    logic [MEM_TAG-1:0]      ctag_q, ctag_d;
    logic [IW-1:0]           inflight_q, inflight_d;
    logic                    tcq_valid_q, tcq_valid_d;
    logic                    done_valid_q, done_valid_d;
    logic                    desc_ready_q, desc_ready_d;
    logic                    err_q, err_d;

    logic [2:0]              mps_sel;
    logic [CW-1:0]           bnd;
    logic [CW-1:0]           chunk_min;
    logic                    issue_hs;
    logic                    conf_ok;

    always_comb begin
        state_d      = state_q;
        laddr_d      = laddr_q;
        raddr_d      = raddr_q;
        rem_d        = rem_q;
        mps_d        = mps_q;
        chunk_d      = chunk_q;
        id_d         = id_q;
        tag_d        = tag_q;
        ctag_d       = ctag_q;
        inflight_d   = inflight_q;
        err_d        = err_q;

        issue_hs = tcq_valid_q & m_tcq_ready;
        conf_ok  = m_tcq_cvalid && (inflight_q != '0);
        mps_sel  = (cfg_max_payload > 3'(MPS_CAP)) ? 3'(MPS_CAP) : cfg_max_payload;
        // beats left before the remote 4 KB page ends; a page-aligned start yields a full page
        bnd      = CW'(1 << PGB) - CW'(raddr_q[PGB-1:0]);
        chunk_min = rem_q;
        if (mps_q < chunk_min) chunk_min = mps_q;
        if (bnd < chunk_min)   chunk_min = bnd;

        case (state_q)
            S_IDLE: begin
                if (s_desc_valid) begin
                    laddr_d = s_desc_laddr;
                    raddr_d = s_desc_raddr;
                    rem_d   = CW'(s_desc_len) + CW'(1);
                    id_d    = s_desc_id;
                    mps_d   = CW'((32'd128 << mps_sel) >> DATA_BITS);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                chunk_d = QW'(chunk_min);
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (issue_hs) begin
                    laddr_d = laddr_q + LW'(chunk_q);
                    raddr_d = raddr_q + RW'(chunk_q);
                    rem_d   = rem_q - CW'(chunk_q);
                    tag_d   = tag_q + MEM_TAG'(1);
                    state_d = (rem_q == CW'(chunk_q)) ? S_DRAIN : S_CALC;
                end
            end
            S_DRAIN: begin
                if (inflight_q == '0) state_d = S_DONE;
            end
            S_DONE: begin
                if (m_done_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // stray confirmations flag an error but never underflow the count
        case ({issue_hs, conf_ok})
            2'b10:   inflight_d = inflight_q + IW'(1);
            2'b01:   inflight_d = inflight_q - IW'(1);
            default: inflight_d = inflight_q;
        endcase

        if (m_tcq_cvalid) begin
            if (inflight_q == '0) begin
                err_d = 1'b1;
            end else begin
                if (m_tcq_ctag != ctag_q) err_d = 1'b1;
                ctag_d = ctag_q + MEM_TAG'(1);
            end
        end

        tcq_valid_d  = (state_d == S_ISSUE) && (inflight_d < IW'(MAX_INFLIGHT));
        done_valid_d = (state_d == S_DONE);
        desc_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            laddr_q      <= '0;
            raddr_q      <= '0;
            rem_q        <= '0;
            mps_q        <= '0;
            chunk_q      <= '0;
            id_q         <= '0;
            tag_q        <= '0;
            ctag_q       <= '0;
            inflight_q   <= '0;
            tcq_valid_q  <= 1'b0;
            done_valid_q <= 1'b0;
            desc_ready_q <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            laddr_q      <= laddr_d;
            raddr_q      <= raddr_d;
            rem_q        <= rem_d;
            mps_q        <= mps_d;
            chunk_q      <= chunk_d;
            id_q         <= id_d;
            tag_q        <= tag_d;
            ctag_q       <= ctag_d;
            inflight_q   <= inflight_d;
            tcq_valid_q  <= tcq_valid_d;
            done_valid_q <= done_valid_d;
            desc_ready_q <= desc_ready_d;
            err_q        <= err_d;
        end
    end

    assign s_desc_ready = desc_ready_q;
    assign m_tcq_valid  = tcq_valid_q;
    assign m_tcq_laddr  = laddr_q;
    assign m_tcq_raddr  = raddr_q;
    assign m_tcq_length = REQUEST_LEN_BITS'(chunk_q - QW'(1));
    assign m_tcq_tag    = tag_q;
    assign m_tcq_cready = 1'b1;
    assign m_done_valid = done_valid_q;
    assign m_done_id    = id_q;
    assign err_tag      = err_q;

endmodule

// File: tb/tb_al_pcie_memwr_sched.sv
// Bench for al_pcie_memwr_sched: randomized descriptors and engine behaviour checked
// against a byte-level model of request splitting, tagging and completion.
module tb_al_pcie_memwr_sched;

    localparam int LAW = 17, RAW = 32, TW = 1, RLB = 6, DB = 4;
    localparam int DLB = 16, IDB = 4, MAXI = 2, CAP = 2;
    localparam int LW = LAW - DB, RW = RAW - DB;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [2:0]     cfg_max_payload = '0;
    logic           s_desc_valid = 1'b0;
    logic           s_desc_ready;
    logic [LW-1:0]  s_desc_laddr = '0;
    logic [RW-1:0]  s_desc_raddr = '0;
    logic [DLB-1:0] s_desc_len = '0;
    logic [IDB-1:0] s_desc_id = '0;
    logic           m_tcq_valid;
    logic           m_tcq_ready = 1'b0;
    logic [LW-1:0]  m_tcq_laddr;
    logic [RW-1:0]  m_tcq_raddr;
    logic [RLB-1:0] m_tcq_length;
    logic [TW-1:0]  m_tcq_tag;
    logic           m_tcq_cvalid = 1'b0;
    logic           m_tcq_cready;
    logic [TW-1:0]  m_tcq_ctag = '0;
    logic           m_done_valid;
    logic           m_done_ready = 1'b0;
    logic [IDB-1:0] m_done_id;
    logic           err_tag;

    always #5 clk = ~clk;

    al_pcie_memwr_sched #(
        .LOCAL_ADDR_WIDTH(LAW), .REMOTE_ADDR_WIDTH(RAW), .MEM_TAG(TW),
        .REQUEST_LEN_BITS(RLB), .DATA_BITS(DB), .DESC_LEN_BITS(DLB),
        .DESC_ID_BITS(IDB), .MAX_INFLIGHT(MAXI), .MPS_CAP(CAP)
    ) dut (
        .clk(clk), .rst(rst), .cfg_max_payload(cfg_max_payload),
        .s_desc_valid(s_desc_valid), .s_desc_ready(s_desc_ready),
        .s_desc_laddr(s_desc_laddr), .s_desc_raddr(s_desc_raddr),
        .s_desc_len(s_desc_len), .s_desc_id(s_desc_id),
        .m_tcq_valid(m_tcq_valid), .m_tcq_ready(m_tcq_ready),
        .m_tcq_laddr(m_tcq_laddr), .m_tcq_raddr(m_tcq_raddr),
        .m_tcq_length(m_tcq_length), .m_tcq_tag(m_tcq_tag),
        .m_tcq_cvalid(m_tcq_cvalid), .m_tcq_cready(m_tcq_cready),
        .m_tcq_ctag(m_tcq_ctag), .m_done_valid(m_done_valid),
        .m_done_ready(m_done_ready), .m_done_id(m_done_id), .err_tag(err_tag)
    );

    typedef struct {
        logic [LW-1:0]  la;
        logic [RW-1:0]  ra;
        logic [RLB-1:0] len;
        logic [TW-1:0]  tag;
    } req_t;

    req_t           exp_q[$];
    logic [TW-1:0]  pend_q[$];
    int             n_checks = 0, n_fail = 0;
    int             issued = 0, confirmed = 0, nreq = 0, exp_n = 0, tag_m = 0;
    int             cyc = 0, start_cyc = 0, first_valid_cyc = -1;
    int             last_hs_cyc = -1, first_hs_cyc = -1;
    bit             done_seen = 0, exp_err = 0;
    logic [IDB-1:0] exp_id = '0;

    // Reference: walk the descriptor in bytes, cutting at MPS and at each 4 KB page end.
    task automatic build_exp(input int cfg, input longint la, input longint ra, input int len);
        longint mps, lb, rb, rem, pl, c;
        req_t   r;
        mps = 128 << ((cfg > CAP) ? CAP : cfg);
        lb = la * 16; rb = ra * 16; rem = longint'(len + 1) * 16;
        exp_n = 0;
        while (rem > 0) begin
            pl = 4096 - (rb % 4096);
            c = rem;
            if (mps < c) c = mps;
            if (pl < c) c = pl;
            r.la = LW'(lb / 16); r.ra = RW'(rb / 16);
            r.len = RLB'(c / 16 - 1); r.tag = TW'(tag_m);
            tag_m = (tag_m + 1) % (1 << TW);
            exp_q.push_back(r);
            exp_n++;
            lb += c; rb += c; rem -= c;
        end
    endtask

    task automatic step_cycle(input int rdy_p, input int conf_p, input int done_p);
        int out;
        @(negedge clk);
        cyc++;
        s_desc_valid = 1'b0;
        out = issued - confirmed;
        n_checks++;
        if (err_tag !== exp_err) begin
            n_fail++; $display("FAIL err_tag: got %b expected %b", err_tag, exp_err);
        end
        if (m_tcq_valid === 1'b1) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            n_checks++;
            if (out >= MAXI) begin
                n_fail++; $display("FAIL inflight_limit: valid with %0d outstanding", out);
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL unexpected_req: valid with no request expected");
            end else if (m_tcq_laddr !== exp_q[0].la || m_tcq_raddr !== exp_q[0].ra ||
                         m_tcq_length !== exp_q[0].len || m_tcq_tag !== exp_q[0].tag) begin
                n_fail++;
                $display("FAIL req_fields: got la=%h ra=%h len=%0d tag=%0d expected la=%h ra=%h len=%0d tag=%0d",
                         m_tcq_laddr, m_tcq_raddr, m_tcq_length, m_tcq_tag,
                         exp_q[0].la, exp_q[0].ra, exp_q[0].len, exp_q[0].tag);
            end
        end
        m_tcq_cvalid = 1'b0;
        if (pend_q.size() > 0 && $urandom_range(99) < conf_p) begin
            m_tcq_cvalid = 1'b1;
            m_tcq_ctag = pend_q.pop_front();
            confirmed++;
        end
        m_tcq_ready = ($urandom_range(99) < rdy_p);
        if (m_tcq_valid === 1'b1 && m_tcq_ready) begin
            n_checks++;
            if (last_hs_cyc >= 0 && cyc - last_hs_cyc < 2) begin
                n_fail++; $display("FAIL hs_spacing: gap %0d expected >= 2", cyc - last_hs_cyc);
            end
            if (nreq == 0) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
            if (exp_q.size() > 0) pend_q.push_back(exp_q.pop_front().tag);
            else pend_q.push_back(m_tcq_tag);
            issued++; nreq++;
        end
        m_done_ready = 1'b0;
        if (m_done_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() != 0 || out != 0) begin
                n_fail++; $display("FAIL done_early: %0d requests left, %0d outstanding", exp_q.size(), out);
            end
            n_checks++;
            if (m_done_id !== exp_id) begin
                n_fail++; $display("FAIL done_id: got %h expected %h", m_done_id, exp_id);
            end
            if ($urandom_range(99) < done_p) begin
                m_done_ready = 1'b1; done_seen = 1'b1;
            end
        end
        cfg_max_payload = 3'($urandom_range(7));
    endtask

    task automatic start_desc(input int cfg, input int la, input int ra, input int len, input int id);
        int k;
        build_exp(cfg, la, ra, len);
        exp_id = IDB'(id); done_seen = 0; nreq = 0; first_valid_cyc = -1; first_hs_cyc = -1;
        k = 0;
        @(negedge clk);
        while (s_desc_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        n_checks++;
        if (k >= 100) begin n_fail++; $display("FAIL desc_ready_timeout: ready never rose"); end
        m_tcq_ready = 1'b0; m_tcq_cvalid = 1'b0; m_done_ready = 1'b0;
        cfg_max_payload = 3'(cfg);
        s_desc_laddr = LW'(la); s_desc_raddr = RW'(ra);
        s_desc_len = DLB'(len); s_desc_id = IDB'(id);
        s_desc_valid = 1'b1;
        start_cyc = cyc;
    endtask

    task automatic service(input int rdy_p, input int conf_p, input int done_p, input int bound);
        for (int i = 0; i < bound && !done_seen; i++) step_cycle(rdy_p, conf_p, done_p);
        n_checks++;
        if (!done_seen) begin n_fail++; $display("FAIL done_timeout: no completion in %0d cycles", bound); end
    endtask

    task automatic run_desc(input int cfg, input int la, input int ra, input int len, input int id,
                            input int rdy_p, input int conf_p, input int done_p);
        int n_expected;
        start_desc(cfg, la, ra, len, id);
        n_expected = exp_n;
        service(rdy_p, conf_p, done_p, 4000);
        n_checks++;
        if (nreq != n_expected) begin
            n_fail++; $display("FAIL req_count: got %0d expected %0d", nreq, n_expected);
        end
        n_checks++;
        if (first_valid_cyc - start_cyc != 2) begin
            n_fail++; $display("FAIL latency: got %0d expected 2", first_valid_cyc - start_cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; s_desc_valid = 1'b0; m_tcq_ready = 1'b0; m_tcq_cvalid = 1'b0; m_done_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        exp_q.delete(); pend_q.delete();
        issued = 0; confirmed = 0; tag_m = 0; exp_err = 0; last_hs_cyc = -1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++; if (s_desc_ready !== 1'b1) begin n_fail++; $display("FAIL rst_desc_ready: got %b expected 1", s_desc_ready); end
        n_checks++; if (m_tcq_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tcq_valid: got %b expected 0", m_tcq_valid); end
        n_checks++; if (m_done_valid !== 1'b0) begin n_fail++; $display("FAIL rst_done_valid: got %b expected 0", m_done_valid); end
        n_checks++; if (err_tag !== 1'b0) begin n_fail++; $display("FAIL rst_err_tag: got %b expected 0", err_tag); end
        n_checks++; if (m_tcq_cready !== 1'b1) begin n_fail++; $display("FAIL cready: got %b expected 1", m_tcq_cready); end
    endtask

    task automatic test_split_example();
        run_desc(1, 0, 32'h1000_0F80 >> 4, 99, 5, 70, 40, 60);
        n_checks++;
        if (nreq != 7) begin n_fail++; $display("FAIL example_count: got %0d expected 7", nreq); end
    endtask

    task automatic test_len0();
        run_desc(2, 13'h55, 32'h0123_0000 >> 4, 0, 9, 100, 100, 100);
        n_checks++;
        if (nreq != 1) begin n_fail++; $display("FAIL len0_count: got %0d expected 1", nreq); end
    endtask

    task automatic test_back_to_back();
        run_desc(3, 100, 0, 127, 11, 100, 100, 100);
        n_checks++;
        if (last_hs_cyc - first_hs_cyc != 2 * (nreq - 1)) begin
            n_fail++; $display("FAIL b2b_rate: span %0d expected %0d", last_hs_cyc - first_hs_cyc, 2 * (nreq - 1));
        end
    endtask

    task automatic test_inflight_limit();
        start_desc(0, 0, 0, 63, 6);
        for (int i = 0; i < 20; i++) step_cycle(100, 0, 0);
        n_checks++; if (nreq != 2) begin n_fail++; $display("FAIL withheld_count: got %0d expected 2", nreq); end
        n_checks++; if (m_tcq_valid !== 1'b0) begin n_fail++; $display("FAIL withheld_valid: got %b expected 0", m_tcq_valid); end
        step_cycle(100, 100, 0);
        for (int i = 0; i < 10; i++) step_cycle(100, 0, 0);
        n_checks++; if (nreq != 3) begin n_fail++; $display("FAIL release_count: got %0d expected 3", nreq); end
        service(100, 100, 100, 2000);
    endtask

    task automatic test_hold();
        start_desc(0, 0, 0, 31, 3);
        for (int i = 0; i < 12; i++) step_cycle(0, 0, 0);
        n_checks++; if (nreq != 0) begin n_fail++; $display("FAIL hold_count: got %0d expected 0", nreq); end
        n_checks++; if (m_tcq_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %b expected 1", m_tcq_valid); end
        service(100, 100, 100, 2000);
    endtask

    task automatic test_err();
        start_desc(2, 0, 0, 0, 7);
        for (int i = 0; i < 10 && nreq == 0; i++) step_cycle(100, 0, 0);
        @(negedge clk);
        m_tcq_ready = 1'b0;
        m_tcq_cvalid = 1'b1;
        m_tcq_ctag = ~pend_q.pop_front();
        confirmed++;
        exp_err = 1'b1;
        service(100, 100, 100, 200);
        for (int i = 0; i < 5; i++) step_cycle(100, 100, 100);
        do_reset();
        step_cycle(0, 0, 0);
        @(negedge clk);
        m_tcq_cvalid = 1'b1; m_tcq_ctag = '0; exp_err = 1'b1;
        step_cycle(0, 0, 0);
        run_desc(1, 40, 255, 20, 12, 80, 80, 80);
        do_reset();
    endtask

    task automatic test_reset_drain();
        start_desc(1, 0, 0, 0, 2);
        for (int i = 0; i < 10 && nreq == 0; i++) step_cycle(100, 0, 0);
        step_cycle(100, 0, 0); step_cycle(100, 0, 0);
        @(negedge clk);
        rst = 1'b1; m_tcq_cvalid = 1'b0; m_tcq_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (m_tcq_valid !== 1'b0) begin n_fail++; $display("FAIL rst_drain_valid: got %b expected 0", m_tcq_valid); end
        n_checks++; if (m_done_valid !== 1'b0) begin n_fail++; $display("FAIL rst_drain_done: got %b expected 0", m_done_valid); end
        rst = 1'b0; m_tcq_ready = 1'b0;
        exp_q.delete(); pend_q.delete();
        issued = 0; confirmed = 0; tag_m = 0; exp_err = 0; last_hs_cyc = -1;
        @(negedge clk);
        n_checks++; if (s_desc_ready !== 1'b1) begin n_fail++; $display("FAIL rst_drain_ready: got %b expected 1", s_desc_ready); end
        run_desc(2, 7, 32'h2000_0FF0 >> 4, 50, 13, 90, 60, 90);
    endtask

    task automatic test_random();
        int ra;
        for (int d = 0; d < 12; d++) begin
            ra = int'((($urandom & 32'hFFFF) << 8) | $urandom_range(255));
            run_desc(int'($urandom_range(7)), int'($urandom_range(8191)), ra,
                     int'($urandom_range(300)), int'($urandom_range(15)),
                     int'($urandom_range(100, 30)), int'($urandom_range(100, 20)),
                     int'($urandom_range(100, 30)));
        end
    endtask

    initial begin
        test_reset();
        test_split_example();
        test_len0();
        test_back_to_back();
        test_inflight_limit();
        test_hold();
        test_err();
        test_reset_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
